// File: rtl/dm_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dm_port_arbiter
// Purpose  : Shares the single data-memory port between the CPU MEM stage and
//            a DMA/loader burst engine. The CPU normally wins. After MAX_WAIT
//            consecutive lost cycles a pending DMA beat is forced through, and
//            the CPU is stalled for that one cycle.
// Ports    : clk, rst                          clock / async active-high reset
//            cpu_valid/we/addr/wdata           MEM-stage access request
//            cpu_rdata, cpu_stall              load data / pipeline hold
//            dma_req/we/addr/len/wdata         burst request and write data
//            dma_beat, dma_rdata, dma_done     beat strobe / read data / end
//            dm_addr/wdata/we, dm_rdata        data-memory port
// Revision : 1.0  initial release
// ============================================================================
module dm_port_arbiter #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int MAX_WAIT  = 4,
    parameter  int MAX_BURST = 8,
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst,
    // CPU MEM stage
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // DMA requester
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_beat,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    // Data memory
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_we,
    input  logic [DATA_W-1:0] dm_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [LEN_W-1:0]  c_max_len   = LEN_W'(MAX_BURST);
    localparam logic [LEN_W-1:0]  c_len_one   = LEN_W'(1);
    localparam logic [WAIT_W-1:0] c_max_wait  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] c_wait_one  = WAIT_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_burst_addr;
    logic              r_burst_we;
    logic [LEN_W-1:0]  r_remaining;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic              w_dma_owns;
    logic [LEN_W-1:0]  w_len_clamped;

    // Ownership is decided within the cycle: the DMA takes the port whenever
    // the CPU is idle, or when the pending beat has already lost MAX_WAIT
    // cycles in a row.
    assign w_dma_owns    = (r_state == S_BURST) &&
                           (!cpu_valid || (r_wait_cnt == c_max_wait));
    assign w_len_clamped = (dma_len > c_max_len) ? c_max_len : dma_len;

    // Read data is shared by both requesters; the strobes say who owns it.
    assign cpu_rdata = dm_rdata;
    assign dma_rdata = dm_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and port mux
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        dma_done    = 1'b0;
        dma_beat    = 1'b0;
        cpu_stall   = 1'b0;
        dm_addr     = cpu_addr;
        dm_wdata    = cpu_wdata;
        dm_we       = cpu_valid & cpu_we;

        case (r_state)
            S_IDLE: begin
                if (dma_req) begin
                    // A zero-length request still completes with a done pulse.
                    w_state_nxt = (w_len_clamped == '0) ? S_DONE : S_BURST;
                end
            end
            S_BURST: begin
                if (w_dma_owns && (r_remaining == c_len_one)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                dma_done    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_dma_owns) begin
            dm_addr   = r_burst_addr;
            dm_wdata  = dma_wdata;
            dm_we     = r_burst_we;
            dma_beat  = 1'b1;
            cpu_stall = cpu_valid;
        end
    end

    // ------------------------------------------------------------------
    // Burst bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_addr <= '0;
            r_burst_we   <= 1'b0;
            r_remaining  <= '0;
            r_wait_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dma_req) begin
                        r_burst_addr <= dma_addr;
                        r_burst_we   <= dma_we;
                        r_remaining  <= w_len_clamped;
                        r_wait_cnt   <= '0;
                    end
                end
                S_BURST: begin
                    if (w_dma_owns) begin
                        // Word stride; wraps naturally at 2^ADDR_W and keeps
                        // whatever low bits the requester supplied.
                        r_burst_addr <= r_burst_addr + c_addr_step;
                        r_remaining  <= r_remaining - c_len_one;
                        r_wait_cnt   <= '0;
                    end else begin
                        // Cannot exceed MAX_WAIT: at MAX_WAIT the DMA owns.
                        r_wait_cnt   <= r_wait_cnt + c_wait_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dm_port_arbiter
// Purpose  : Randomized scoreboard bench for dm_port_arbiter. The stimulus
//            side decides every cycle's inputs, works out from the arbitration
//            rules who should own the port, and queues the expected response.
//            A negedge monitor pops the queue and compares against the DUT.
//            A small word memory stands in for DM.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_dm_port_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;
    localparam int LEN_W     = $clog2(MAX_BURST + 1);

    localparam int K_BEAT = 0;
    localparam int K_DONE = 1;
    localparam int K_CPU  = 2;

    logic              clk;
    logic              rst;
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [LEN_W-1:0]  dma_len;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_beat;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_done;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [DATA_W-1:0] dm_rdata;

    dm_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_valid(cpu_valid),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_len  (dma_len),
        .dma_wdata(dma_wdata),
        .dma_beat (dma_beat),
        .dma_rdata(dma_rdata),
        .dma_done (dma_done),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata)
    );

    // ------------------------------------------------------------------
    // Clock, cycle counter, DM stand-in (256 words, indexed by addr[9:2])
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[9:2]] <= dm_wdata;
    end
    assign dm_rdata = mem[dm_addr[9:2]];

    // Reference memory: what DM should hold according to the model.
    logic [DATA_W-1:0] ref_mem [0:255];

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int                cyc;
        int                kind;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic              stall;
    } ev_t;

    ev_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops everything expected for the current cycle and compares.
    ev_t m_ev;
    ev_t m_beat;
    ev_t m_cpu;
    bit  m_eb;
    bit  m_ed;
    bit  m_ec;
    always @(negedge clk) begin
        m_eb = 1'b0;
        m_ed = 1'b0;
        m_ec = 1'b0;
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            m_ev = q.pop_front();
            if (m_ev.cyc != cyc) begin
                chk("stale_event", 32'(cyc), 32'(m_ev.cyc));
            end else if (m_ev.kind == K_BEAT) begin
                m_eb = 1'b1;
                m_beat = m_ev;
            end else if (m_ev.kind == K_DONE) begin
                m_ed = 1'b1;
            end else begin
                m_ec = 1'b1;
                m_cpu = m_ev;
            end
        end
        chk("dma_beat", 32'(dma_beat), 32'(m_eb));
        chk("dma_done", 32'(dma_done), 32'(m_ed));
        if (m_eb && dma_beat) begin
            chk("beat_addr",  dm_addr, m_beat.addr);
            chk("beat_we",    32'(dm_we), 32'(m_beat.we));
            chk("beat_stall", 32'(cpu_stall), 32'(m_beat.stall));
            if (m_beat.we) chk("beat_wdata", dm_wdata, m_beat.wdata);
            else           chk("beat_rdata", dma_rdata, m_beat.rdata);
        end
        if (m_ec) begin
            chk("cpu_stall", 32'(cpu_stall), 32'(0));
            chk("cpu_addr",  dm_addr, m_cpu.addr);
            chk("cpu_we",    32'(dm_we), 32'(m_cpu.we));
            if (m_cpu.we) chk("cpu_wdata", dm_wdata, m_cpu.wdata);
            else          chk("cpu_rdata", cpu_rdata, m_cpu.rdata);
        end
        if (!m_eb && !m_ec) begin
            chk("idle_dm_we",  32'(dm_we), 32'(0));
            chk("idle_stall",  32'(cpu_stall), 32'(0));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Inputs for this cycle are already applied; queue what should happen,
    // update the reference memory, and move to the next cycle.
    task automatic step(input bit own, input logic [ADDR_W-1:0] baddr,
                        input logic bwe, input bit done);
        ev_t e;
        if (own) begin
            e = '{cyc: cyc, kind: K_BEAT, addr: baddr, we: bwe, wdata: dma_wdata,
                  rdata: ref_mem[baddr[9:2]], stall: cpu_valid};
            q.push_back(e);
            if (bwe) ref_mem[baddr[9:2]] = dma_wdata;
        end else if (cpu_valid) begin
            e = '{cyc: cyc, kind: K_CPU, addr: cpu_addr, we: cpu_we, wdata: cpu_wdata,
                  rdata: ref_mem[cpu_addr[9:2]], stall: 1'b0};
            q.push_back(e);
            if (cpu_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
        end
        if (done) begin
            e = '{cyc: cyc, kind: K_DONE, addr: '0, we: 1'b0, wdata: '0,
                  rdata: '0, stall: 1'b0};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cpu(input int pct, input bit writes);
        cpu_valid = ($urandom_range(0, 99) < pct);
        cpu_we    = writes ? 1'($urandom) : 1'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
    endtask

    // DMA inputs other than the accepted request are noise and must be ignored.
    task automatic rand_dma_noise(input logic req);
        dma_req   = req;
        dma_we    = 1'($urandom);
        dma_addr  = $urandom;
        dma_len   = LEN_W'($urandom);
        dma_wdata = $urandom;
    endtask

    task automatic idle_cycle(input int pct);
        rand_cpu(pct, 1'b1);
        rand_dma_noise(1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // One complete burst from the IDLE request cycle through the done cycle.
    task automatic run_burst(input logic [ADDR_W-1:0] a, input int len,
                             input logic we, input int pct, input bit writes);
        int eff;
        int k;
        int lost;
        rand_cpu(pct, writes);
        dma_req   = 1'b1;
        dma_we    = we;
        dma_addr  = a;
        dma_len   = LEN_W'(len);
        dma_wdata = $urandom;
        step(1'b0, '0, 1'b0, 1'b0);
        eff  = (len > MAX_BURST) ? MAX_BURST : len;
        k    = 0;
        lost = 0;
        while (k < eff) begin
            rand_cpu(pct, writes);
            rand_dma_noise(1'($urandom));
            if (!cpu_valid || lost == MAX_WAIT) begin
                step(1'b1, a + 32'(4 * k), we, 1'b0);
                k++;
                lost = 0;
            end else begin
                step(1'b0, '0, 1'b0, 1'b0);
                lost++;
            end
        end
        // Done cycle, with a request present that must be ignored.
        rand_cpu(pct, writes);
        rand_dma_noise(1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        cpu_valid = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dma_req   = 1'b0;
        dma_we    = 1'b0;
        dma_addr  = '0;
        dma_len   = '0;
        dma_wdata = '0;

        @(posedge clk);
        #1;
        // Reset state: CPU path live, DMA strobes low, even with a request.
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1234_5678;
        dma_req = 1'b1; dma_len = LEN_W'(3);
        step(1'b0, '0, 1'b0, 1'b0);
        rand_dma_noise(1'b0);
        cpu_valid = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;

        // Fill the whole memory through the CPU so both models agree.
        for (int i = 0; i < 256; i++) begin
            cpu_valid = 1'b1; cpu_we = 1'b1;
            cpu_addr  = 32'(i * 4); cpu_wdata = $urandom;
            step(1'b0, '0, 1'b0, 1'b0);
        end

        // CPU only: store 0xA5 at 0x10, then load it back.
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
        step(1'b0, '0, 1'b0, 1'b0);
        cpu_we = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);

        // Uncontended write burst.
        run_burst(32'h0000_0020, 3, 1'b1, 0, 1'b0);
        idle_cycle(0);
        // Starvation guard: CPU busy every cycle, 2-beat read.
        run_burst(32'h0000_0080, 2, 1'b0, 100, 1'b0);
        idle_cycle(0);
        // Length edge cases.
        run_burst(32'h0000_0100, 0, 1'b1, 50, 1'b1);
        run_burst(32'h0000_0200, 12, 1'b1, 0, 1'b0);
        run_burst(32'h0000_0200, 15, 1'b0, 60, 1'b1);
        // Address wrap.
        run_burst(32'hFFFF_FFFC, 2, 1'b1, 0, 1'b0);
        run_burst(32'hFFFF_FFFC, 2, 1'b0, 0, 1'b0);

        // Reset after beat 2 of a 5-beat write.
        cpu_valid = 1'b0; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0300;
        dma_len = LEN_W'(5); dma_wdata = $urandom;
        step(1'b0, '0, 1'b0, 1'b0);
        dma_req = 1'b0; dma_wdata = $urandom;
        step(1'b1, 32'h0000_0300, 1'b1, 1'b0);
        dma_wdata = $urandom;
        step(1'b1, 32'h0000_0304, 1'b1, 1'b0);
        rst = 1'b1; dma_wdata = $urandom;
        step(1'b0, '0, 1'b0, 1'b0);
        dma_wdata = $urandom;
        step(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b0;
        idle_cycle(0);
        // Read back the region: only the first two words may have changed.
        run_burst(32'h0000_0300, 5, 1'b0, 30, 1'b0);

        // Randomized bursts with random CPU traffic and gaps.
        for (int b = 0; b < 40; b++) begin
            run_burst($urandom, $urandom_range(0, 15), 1'($urandom),
                      $urandom_range(0, 100), 1'b1);
            for (int g = $urandom_range(0, 3); g > 0; g--) idle_cycle(50);
        end

        for (int i = 0; i < 3; i++) idle_cycle(0);
        chk("leftover_events", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Shares the single data-memory (DM) port between the pipelined CPU's MEM stage and a DMA/loader requester that moves bursts of words. The CPU has priority, but a starvation guard forces the CPU to stall for one cycle so the DMA can take one beat. The block sits between the EX/MEM pipeline register outputs and the `DM` instance. Its `cpu_stall` output feeds the pipeline's stall logic, alongside PC/IF-ID write enable.

## Interface
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `MAX_WAIT`, 4: maximum consecutive cycles a pending DMA beat may lose to the CPU
- `MAX_BURST`, 8: maximum beats per burst; `LEN_W = $clog2(MAX_BURST+1)`

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cpu_valid`  in  1  MEM stage performs a load or store this cycle
- `cpu_we`  in  1  MEM stage access is a store
- `cpu_addr`  in  ADDR_W  MEM-stage address
- `cpu_wdata`  in  DATA_W  MEM-stage store data
- `cpu_rdata`  out  DATA_W  load data, equal to `dm_rdata`
- `cpu_stall`  out  1  CPU access not serviced this cycle; pipeline must hold
- `dma_req`  in  1  start a burst; sampled only in IDLE
- `dma_we`  in  1  burst direction: 1 = write to DM
- `dma_addr`  in  ADDR_W  burst start address
- `dma_len`  in  LEN_W  beat count
- `dma_wdata`  in  DATA_W  write data for the current beat
- `dma_beat`  out  1  DMA beat performed this cycle
- `dma_rdata`  out  DATA_W  read data, equal to `dm_rdata`; valid when `dma_beat & ~burst_we`
- `dma_done`  out  1  one-cycle pulse at burst completion
- `dm_addr`  out  ADDR_W  to `DM.MemAddr`
- `dm_wdata`  out  DATA_W  to `DM.MemWriteData`
- `dm_we`  out  1  to `DM.MemWrite`
- `dm_rdata`  in  DATA_W  from `DM.MemReadData`; combinational read

## Operation
State machine states: IDLE, BURST, DONE.

Registers:
- `burst_addr`, `burst_we`
- `remaining` (LEN_W bits)
- `wait_cnt` (`$clog2(MAX_WAIT+1)` bits)

IDLE:
- If `dma_req` is high, latch `dma_addr`, `dma_we` and `min(dma_len, MAX_BURST)` into `remaining`; clear `wait_cnt`.
- If the latched length is 0, go to DONE. Otherwise go to BURST.

BURST: the port owner for the cycle is decided combinationally.
- **DMA owns the port** if `~cpu_valid`, or if `wait_cnt == MAX_WAIT`. On that edge:
  - `burst_addr += 4`, modulo 2^ADDR_W.
  - `remaining -= 1`.
  - `wait_cnt` clears.
  - If `remaining` was 1, go to DONE.
- **CPU owns the port** otherwise; `wait_cnt += 1`.

DONE:
- `dma_done = 1` for exactly this one cycle.
- Go to IDLE unconditionally.
- A `dma_req` seen in DONE is ignored. A new burst is accepted in IDLE on the following cycle.

Port mux (combinational):
- **DMA owns:** `dm_addr = burst_addr`, `dm_wdata = dma_wdata`, `dm_we = burst_we`, `dma_beat = 1`, `cpu_stall = cpu_valid`.
- **Otherwise (IDLE/DONE/CPU owns):** `dm_addr = cpu_addr`, `dm_wdata = cpu_wdata`, `dm_we = cpu_valid & cpu_we`, `dma_beat = 0`, `cpu_stall = 0`.

Address rules:
- The low address bits `burst_addr[1:0]` are passed through unaltered.
- No alignment check is performed.

`dma_req` held high during BURST or DONE has no effect.

Reset:
- Asynchronous `rst` forces IDLE, `remaining = 0`, `wait_cnt = 0`, `burst_addr = 0`, `burst_we = 0`.
- Any burst in progress is abandoned. No `dma_done` is issued for it, and no further DM write occurs.

## Timing
- Reset values: `dma_done = 0`, `dma_beat = 0`, `cpu_stall = 0`, `dm_we = cpu_valid & cpu_we`, `dm_addr = cpu_addr`.
- Burst start: `dma_req` sampled in IDLE at edge N; the first beat is possible in cycle N+1.
- DM writes commit at the rising edge that ends the owning cycle.
- DMA read data is valid in the same cycle as `dma_beat`.
- Uncontended burst of L beats: beats occupy cycles N+1 .. N+L; `dma_done` is high in cycle N+L+1.
- Worst-case gap between DMA beats under continuous CPU traffic: MAX_WAIT CPU cycles, then 1 forced DMA cycle.
  - Max CPU stall: 1 cycle per forced beat.
  - Guaranteed bandwidth: 1 beat per MAX_WAIT+1 cycles.
- Simultaneous `cpu_valid` and an uncontended DMA beat (`wait_cnt < MAX_WAIT`): the CPU wins.

## Test plan
- **CPU only.** `cpu_valid=1`, `cpu_we=1`, `cpu_addr=0x10`, `cpu_wdata=0xA5`, no DMA.
  - Required: `dm_we=1`, `dm_addr=0x10`, `cpu_stall=0`; DM[0x10] reads 0xA5 the next cycle.
- **Uncontended DMA write.** `dma_addr=0x20`, `dma_len=3`, `dma_we=1`, `cpu_valid=0`.
  - Required: `dma_beat` high for 3 consecutive cycles at addresses 0x20, 0x24, 0x28; `dma_done` high 1 cycle later.
- **Starvation guard.** `cpu_valid` held 1, DMA read with `dma_len=2`, `MAX_WAIT=4`.
  - Required: each beat occurs after exactly 4 CPU cycles; `cpu_stall=1` only on the 2 beat cycles; `dma_done` in cycle 11 after acceptance.
- **Length edge cases.**
  - `dma_len=0`: `dma_done` pulses on the next cycle; no `dma_beat`; `dm_we` never driven by the DMA.
  - `dma_len=12` with `MAX_BURST=8`: exactly 8 beats.
- **Address wrap.** `dma_addr=0xFFFFFFFC`, `dma_len=2`.
  - Required: beat addresses 0xFFFFFFFC then 0x00000000.
- **Reset mid-burst.** `rst` pulsed after beat 2 of a 5-beat write.
  - Required: all outputs take their reset values immediately; no further DMA writes; no `dma_done`; a new `dma_req` is accepted normally after reset is released.
